// File: rtl/stack_ctrl.sv
// stack_ctrl
//   Sequences PUSH / POP / CALL / RET for the 16-bit processor stack. Owns the
//   stack pointer, drives a single-port data-memory request/ack handshake and
//   returns pop data / return targets. Overflow and underflow are detected at
//   accept time, so a rejected operation never touches memory.
//
//   Stack model: full-descending, SP addresses the next free slot.
//     push: mem[SP] <= data, SP <= SP-1
//     pop : data <= mem[SP+1], SP <= SP+1
//
//   Handshakes:
//     op    : a request is taken on a rising edge where op_valid && op_ready.
//             op_ready is high only in IDLE; the requester holds op_valid and
//             its operands until accepted.
//     memory: mem_req is held with stable mem_we/mem_addr/mem_wdata until a
//             single-cycle mem_ack; mem_rdata is valid alongside mem_ack.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     op_valid, op, op_ready request channel (00 PUSH, 01 POP, 10 CALL, 11 RET)
//     push_data, pc_next    operands, sampled at accept
//     mem_*                 data-memory handshake
//     sp_out                current stack pointer
//     pop_data, pc_target   last value read by POP/RET (held)
//     pc_load               one-cycle pulse on a successful RET
//     done, fault           completion pulse; fault marks a rejected op
//     overflow, underflow   sticky error history, cleared only by reset
//     o_dbg_state           current FSM state, for observation only
module stack_ctrl #(
   parameter int                DATA_W      = 16,
   parameter logic [DATA_W-1:0] SP_RESET    = 16'hFFFF,
   parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hFF00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   input  logic [1:0]        op,
   output logic              op_ready,
   input  logic [DATA_W-1:0] push_data,
   input  logic [DATA_W-1:0] pc_next,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] sp_out,
   output logic [DATA_W-1:0] pop_data,
   output logic              pc_load,
   output logic [DATA_W-1:0] pc_target,
   output logic              done,
   output logic              fault,
   output logic              overflow,
   output logic              underflow,
   output logic [2:0]        o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic [1:0]        OP_CALL = 2'b10;
   localparam logic [1:0]        OP_RET  = 2'b11;
   localparam logic [DATA_W-1:0] ONE     = 1;

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_sp;
   logic [1:0]        r_op;
   logic [DATA_W-1:0] r_operand;
   logic [DATA_W-1:0] r_pop_data;
   logic              r_overflow;
   logic              r_underflow;
   logic              w_accept;
   logic [DATA_W-1:0] w_sp_inc;

   assign w_accept = (r_state == S_IDLE) && op_valid;
   assign w_sp_inc = r_sp + ONE;

   // Next-state and registered-state-decoded outputs. Memory outputs depend on
   // state and registers only, so they cannot move while mem_req is high.
   always_comb begin
      w_next    = r_state;
      op_ready  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      done      = 1'b0;
      fault     = 1'b0;
      pc_load   = 1'b0;
      case (r_state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               // op[0]==0 is PUSH/CALL (writes), op[0]==1 is POP/RET (reads)
               if (!op[0])
                  w_next = (r_sp < STACK_LIMIT) ? S_FAULT : S_WRITE;
               else
                  w_next = (r_sp == SP_RESET) ? S_FAULT : S_READ;
            end
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_sp;
            mem_wdata = r_operand;
            if (mem_ack) w_next = S_DONE;
         end
         S_READ: begin
            mem_req  = 1'b1;
            mem_addr = w_sp_inc;
            if (mem_ack) w_next = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            pc_load = (r_op == OP_RET);
            w_next  = S_IDLE;
         end
         S_FAULT: begin
            done   = 1'b1;
            fault  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sp        <= SP_RESET;
         r_op        <= '0;
         r_operand   <= '0;
         r_pop_data  <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op      <= op;
            r_operand <= (op == OP_CALL) ? pc_next : push_data;
            if (w_next == S_FAULT) begin
               if (!op[0]) r_overflow  <= 1'b1;
               else        r_underflow <= 1'b1;
            end
         end
         if ((r_state == S_WRITE) && mem_ack)
            r_sp <= r_sp - ONE;
         if ((r_state == S_READ) && mem_ack) begin
            r_sp       <= w_sp_inc;
            r_pop_data <= mem_rdata;
         end
      end
   end

   assign sp_out      = r_sp;
   assign pop_data    = r_pop_data;
   assign pc_target   = r_pop_data;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        op_valid;
  logic [1:0]  op;
  logic        op_ready;
  logic [15:0] push_data;
  logic [15:0] pc_next;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] sp_out;
  logic [15:0] pop_data;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        done;
  logic        fault;
  logic        overflow;
  logic        underflow;
  logic [2:0]  dbg_state;

  stack_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .op_ready    (op_ready),
    .push_data   (push_data),
    .pc_next     (pc_next),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .sp_out      (sp_out),
    .pop_data    (pop_data),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .done        (done),
    .fault       (fault),
    .overflow    (overflow),
    .underflow   (underflow),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_mem_q[$];   // {we, addr, wdata}
  logic [49:0] exp_done_q[$];  // {fault, pc_load, pop_data, pc_target, sp_out}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic exp_w(input logic [15:0] a, input logic [15:0] d);
    exp_mem_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_r(input logic [15:0] a);
    exp_mem_q.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic exp_d(input logic f, input logic pl, input logic [15:0] pd, input logic [15:0] sp);
    exp_done_q.push_back({f, pl, pd, pd, sp});
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem_model [0:65535];
  int ack_delay = 0;
  int wait_cnt  = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        req_seen = 1'b0;
  logic [32:0] cur_exp;
  logic [49:0] d_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          if (exp_mem_q.size() == 0) begin
            fail_now("mem_req_unexpected");
            cur_exp = {mem_we, mem_addr, mem_wdata};
          end else begin
            cur_exp = exp_mem_q.pop_front();
            if (cur_exp[32]) chk("mem_write", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, cur_exp});
            else             chk("mem_read", {47'd0, mem_we, mem_addr}, {47'd0, cur_exp[32:16]});
          end
        end else begin
          // request fields must hold until the ack
          if (cur_exp[32]) chk("mem_hold", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, cur_exp});
          else             chk("mem_hold", {47'd0, mem_we, mem_addr}, {47'd0, cur_exp[32:16]});
        end
      end else begin
        req_seen = 1'b0;
      end

      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          d_exp = exp_done_q.pop_front();
          chk("done_resp", {14'd0, fault, pc_load, pop_data, pc_target, sp_out}, {14'd0, d_exp});
        end
      end else if (fault === 1'b1 || pc_load === 1'b1) begin
        fail_now("pulse_without_done");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [15:0] d, input logic [15:0] p);
    int n = 0;
    @(negedge clk);
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("op_ready_timeout");
    op_valid  = 1'b1;
    op        = o;
    push_data = d;
    pc_next   = p;
    @(negedge clk);
    op_valid  = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((exp_mem_q.size() != 0 || exp_done_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("queues_drained", exp_mem_q.size() + exp_done_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    op_valid  = 1'b0;
    op        = OP_PUSH;
    push_data = 16'h0000;
    pc_next   = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_sp", sp_out, 16'hFFFF);
    chk("rst_ready", op_ready, 1'b1);
    chk("rst_req", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_pulses", {done, fault, pc_load}, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    chk("rst_pop", {pop_data, pc_target}, 0);

    // PUSH 1234, ack in the first request cycle; check latency
    exp_w(16'hFFFF, 16'h1234);
    exp_d(1'b0, 1'b0, 16'h0000, 16'hFFFE);
    issue(OP_PUSH, 16'h1234, 16'h0000);
    chk("lat_req_cycle", {mem_req, done}, 2'b10);
    @(negedge clk);
    chk("lat_done_cycle", {mem_req, done}, 2'b01);
    chk("push1_sp", sp_out, 16'hFFFE);

    // POP back to empty
    exp_r(16'hFFFF);
    exp_d(1'b0, 1'b0, 16'h1234, 16'hFFFF);
    issue(OP_POP, 16'h0000, 16'h0000);

    // PUSH AAAA, PUSH BBBB, POP, POP
    exp_w(16'hFFFF, 16'hAAAA); exp_d(1'b0, 1'b0, 16'h1234, 16'hFFFE);
    issue(OP_PUSH, 16'hAAAA, 16'h0000);
    exp_w(16'hFFFE, 16'hBBBB); exp_d(1'b0, 1'b0, 16'h1234, 16'hFFFD);
    issue(OP_PUSH, 16'hBBBB, 16'h0000);
    exp_r(16'hFFFE);           exp_d(1'b0, 1'b0, 16'hBBBB, 16'hFFFE);
    issue(OP_POP, 16'h0000, 16'h0000);
    exp_r(16'hFFFF);           exp_d(1'b0, 1'b0, 16'hAAAA, 16'hFFFF);
    issue(OP_POP, 16'h0000, 16'h0000);

    // CALL 0040 (push_data must be ignored), then RET
    exp_w(16'hFFFF, 16'h0040); exp_d(1'b0, 1'b0, 16'hAAAA, 16'hFFFE);
    issue(OP_CALL, 16'h9999, 16'h0040);
    exp_r(16'hFFFF);           exp_d(1'b0, 1'b1, 16'h0040, 16'hFFFF);
    issue(OP_RET, 16'h0000, 16'h0000);
    wait_drained();

    // underflow: POP and RET on empty stack
    exp_d(1'b1, 1'b0, 16'h0040, 16'hFFFF);
    issue(OP_POP, 16'h0000, 16'h0000);
    exp_d(1'b1, 1'b0, 16'h0040, 16'hFFFF);
    issue(OP_RET, 16'h0000, 16'h0000);
    wait_drained();
    chk("underflow_set", {overflow, underflow}, 2'b01);

    // a following PUSH completes; the flag stays
    exp_w(16'hFFFF, 16'h7777); exp_d(1'b0, 1'b0, 16'h0040, 16'hFFFE);
    issue(OP_PUSH, 16'h7777, 16'h0000);
    exp_r(16'hFFFF);           exp_d(1'b0, 1'b0, 16'h7777, 16'hFFFF);
    issue(OP_POP, 16'h0000, 16'h0000);
    wait_drained();
    chk("underflow_sticky", {overflow, underflow}, 2'b01);

    // fill 256 slots FFFF..FF00, mixing wait states
    for (int i = 0; i < 256; i++) begin
      ack_delay = i % 3;
      exp_w(16'hFFFF - 16'(i), 16'(i) ^ 16'hC3C3);
      exp_d(1'b0, 1'b0, 16'h7777, 16'hFFFE - 16'(i));
      issue(OP_PUSH, 16'(i) ^ 16'hC3C3, 16'h0000);
    end
    ack_delay = 0;
    wait_drained();
    chk("fill_sp", sp_out, 16'hFEFF);

    // one more PUSH and a CALL overflow
    exp_d(1'b1, 1'b0, 16'h7777, 16'hFEFF);
    issue(OP_PUSH, 16'hDEAD, 16'h0000);
    exp_d(1'b1, 1'b0, 16'h7777, 16'hFEFF);
    issue(OP_CALL, 16'h0000, 16'h0123);
    wait_drained();
    chk("overflow_set", {overflow, underflow}, 2'b11);
    chk("overflow_sp", sp_out, 16'hFEFF);

    // flags do not block: POP returns the last pushed value (i=255)
    exp_r(16'hFF00); exp_d(1'b0, 1'b0, 16'h00FF ^ 16'hC3C3, 16'hFF00);
    issue(OP_POP, 16'h0000, 16'h0000);
    wait_drained();

    // reset clears everything
    do_reset();
    chk("rst2_sp", sp_out, 16'hFFFF);
    chk("rst2_flags", {overflow, underflow}, 0);
    chk("rst2_pop", {pop_data, pc_target}, 0);

    // reset during a stalled write aborts it
    ack_delay = 3;
    exp_w(16'hFFFF, 16'h5555);
    issue(OP_PUSH, 16'h5555, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_req", mem_req, 1'b0);
    chk("abort_sp", sp_out, 16'hFFFF);
    chk("abort_ready", op_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done", {done, op_ready}, 2'b01);

    // normal op afterwards with one wait cycle
    ack_delay = 1;
    exp_w(16'hFFFF, 16'h6543); exp_d(1'b0, 1'b0, 16'h0000, 16'hFFFE);
    issue(OP_PUSH, 16'h6543, 16'h0000);
    exp_r(16'hFFFF);           exp_d(1'b0, 1'b0, 16'h6543, 16'hFFFF);
    issue(OP_POP, 16'h0000, 16'h0000);
    wait_drained();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequences all stack traffic for the 16-bit processor: PUSH, POP, CALL and RET requests from the control unit.
- Owns the stack pointer value and drives the single-port data-memory handshake.
- Returns pop data or a return target to the datapath.
- Detects overflow and underflow before any memory access is issued.

Parameters:
SP_RESET, 16'hFFFF, stack pointer value after reset; an empty stack has SP == SP_RESET
STACK_LIMIT, 16'hFF00, lowest address a push may write
DATA_W, 16, data/address width; fixed at 16, not to be overridden

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
op_valid  input  1  operation request strobe
op  input  2  00 PUSH, 01 POP, 10 CALL, 11 RET
op_ready  output  1  high only in IDLE; a request is accepted when op_valid && op_ready
push_data  input  16  PUSH operand, sampled at accept
pc_next  input  16  CALL return address, sampled at accept
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  16  memory address
mem_wdata  output  16  write data
mem_rdata  input  16  read data, valid with mem_ack
mem_ack  input  1  memory completion, single-cycle pulse
sp_out  output  16  current stack pointer
pop_data  output  16  data from the last POP/RET, held until the next POP/RET
pc_load  output  1  one-cycle pulse with done on a successful RET
pc_target  output  16  return address; equals pop_data
done  output  1  one-cycle completion pulse for every accepted op
fault  output  1  with done; operation was rejected
overflow  output  1  sticky; cleared only by reset
underflow  output  1  sticky; cleared only by reset

Behaviour:
- Stack model: full-descending. SP addresses the next free slot.
  - Push: write mem[SP], then SP <= SP-1.
  - Pop: read mem[SP+1], then SP <= SP+1.
- Reset (synchronous, at a posedge with reset=1):
  - state=IDLE, sp_out=SP_RESET.
  - mem_req, mem_we, mem_addr, mem_wdata, pop_data, pc_target, pc_load, done, fault, overflow, underflow all 0.
  - op_ready=1 from the first cycle after reset.
  - Reset in any state aborts the operation: mem_req drops at that edge, SP is restored to SP_RESET, and no done pulse is issued. A late mem_ack after reset is ignored.
- FSM states: IDLE, WRITE, READ, DONE, FAULT.
- IDLE, on accept: latch op and the operand (push_data for PUSH, pc_next for CALL), then evaluate:
  - PUSH/CALL with SP < STACK_LIMIT -> FAULT, set overflow.
  - POP/RET with SP == SP_RESET -> FAULT, set underflow.
  - Otherwise PUSH/CALL -> WRITE; POP/RET -> READ.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=SP, mem_wdata=latched operand.
  - Stays in WRITE until mem_ack. On ack: SP <= SP-1 (16-bit), -> DONE.
- READ:
  - mem_req=1, mem_we=0, mem_addr=SP+1 (16-bit add).
  - Stays in READ until mem_ack. On ack: pop_data <= mem_rdata, pc_target <= mem_rdata, SP <= SP+1, -> DONE.
- DONE: done=1 for one cycle; pc_load=1 if the op was RET. -> IDLE.
- FAULT: done=1, fault=1 for one cycle; SP unchanged; no memory request. -> IDLE.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req=1. mem_req=0 in IDLE, DONE and FAULT.
- Latency with mem_ack in the first request cycle: accept at edge T, mem_req during cycle T+1, done during cycle T+2. Minimum op-to-op spacing is 3 cycles. Each wait cycle on mem_ack adds one cycle.
- Requests are ignored while op_ready=0; the requester holds op_valid until accepted.
- Arithmetic: 16-bit, no carry-out. Wrap-around at 16'hFFFF is unreachable by construction, because underflow is checked before any SP+1.
- Fault flags do not block later operations; they only record history.

Test Plan:
- Reset, then PUSH 16'h1234 with mem_ack in the first request cycle -> write at addr FFFF, data 1234; done two cycles after accept; sp_out=FFFE.
- PUSH 16'hAAAA, PUSH 16'hBBBB, POP, POP -> writes at FFFF then FFFE; pops read FFFE then FFFF; pop_data BBBB then AAAA; final sp_out=FFFF.
- CALL with pc_next=16'h0040, then RET -> mem[FFFF]=0040; RET asserts pc_load for one cycle with pc_target=0040; sp_out=FFFF.
- POP from reset state -> no mem_req; done=fault=1 for one cycle; underflow=1 and stays high; sp_out stays FFFF. A following PUSH completes normally.
- Fill the stack from SP=FFFF down to SP=FEFF (256 pushes), then one more PUSH -> fault, overflow=1, SP stays FEFF.
- PUSH with mem_ack delayed 3 cycles, reset asserted in the second wait cycle -> mem_req low after that edge; sp_out=FFFF; no done; op_ready=1 on the next cycle.
